// File: rtl/booth_mul_pkg.sv
// Shared constants for the round-robin arbitrated Booth multiplier: state encoding and datapath widths.
package booth_mul_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CALC  = 2'd1;
  localparam state_t ST_CALC2 = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/booth_mul_arbiter_mult.sv
// Combinational signed 16x16->32 multiplier using radix-4 Booth recoding of y.
module BoothMultiplier
  import booth_mul_pkg::*;
(
  output logic [PROD_W-1:0] z,
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y
);

  logic [OP_W:0]       yext;
  logic [PROD_W-1:0]   xs;
  logic [PROD_W-1:0]   pp;
  logic [PROD_W-1:0]   acc;
  logic [2:0]          grp;

  // Arithmetic is modulo 2^32; the full signed product always fits, so wrap is harmless.
  always_comb begin
    yext = {y, 1'b0};
    xs   = {{(PROD_W-OP_W){x[OP_W-1]}}, x};
    acc  = '0;
    pp   = '0;
    grp  = '0;
    for (int i = 0; i < OP_W/2; i++) begin
      grp = yext[2*i +: 3];
      case (grp)
        3'b001, 3'b010: pp = xs;
        3'b011:         pp = xs << 1;
        3'b100:         pp = -(xs << 1);
        3'b101, 3'b110: pp = -xs;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2*i));
    end
    z = acc;
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier among NREQ requesters.
// Define BOOTH_MUL_ARB_OUTREG_EN to add a multiplier output register (state CALC2, one extra cycle).
module booth_mul_arbiter
  import booth_mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [PROD_W-1:0] rsp_z,
  output logic              busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t             state;
  logic [GW-1:0]      grant;
  logic [GW-1:0]      last_grant;
  logic [GW-1:0]      pick;
  logic               found;
  int                 idx;
  logic [W-1:0]       x_reg;
  logic [W-1:0]       y_reg;
  logic [PROD_W-1:0]  z_reg;
  logic [PROD_W-1:0]  product;
`ifdef BOOTH_MUL_ARB_OUTREG_EN
  logic [PROD_W-1:0]  pipe_reg;
`endif

  BoothMultiplier u_mult (
    .z (product),
    .x (x_reg),
    .y (y_reg)
  );

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  assign req_ready = (state == ST_IDLE && found && !rst) ? (NREQ'(1) << pick) : '0;
  assign rsp_valid = (state == ST_RESP && !rst) ? (NREQ'(1) << grant) : '0;
  assign rsp_z     = z_reg;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= GW'(NREQ-1);
      grant      <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      z_reg      <= '0;
`ifdef BOOTH_MUL_ARB_OUTREG_EN
      pipe_reg   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant <= pick;
            x_reg <= req_x[int'(pick)*W +: W];
            y_reg <= req_y[int'(pick)*W +: W];
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
`ifdef BOOTH_MUL_ARB_OUTREG_EN
          pipe_reg <= product;
          state    <= ST_CALC2;
`else
          z_reg <= product;
          state <= ST_RESP;
`endif
        end
`ifdef BOOTH_MUL_ARB_OUTREG_EN
        ST_CALC2: begin
          z_reg <= pipe_reg;
          state <= ST_RESP;
        end
`endif
        ST_RESP: begin
          // Only the owner's rsp_ready can retire the response.
          if (rsp_ready[grant]) begin
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter: directed corners then randomized traffic.
module tb_booth_mul_arbiter;

  localparam int NREQ = 4;
`ifdef BOOTH_MUL_ARB_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*16-1:0]   req_x = '0;
  logic [NREQ*16-1:0]   req_y = '0;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready = '0;
  logic [31:0]          rsp_z;
  logic                 busy;

  booth_mul_arbiter #(.NREQ(NREQ), .W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          owner;
    logic [31:0] prod;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int sa, sb_, p;
    sa = $signed(a);
    sb_ = $signed(b);
    p = sa * sb_;
    return p;
  endfunction

  // Reference model: one operation in flight, response due LAT cycles after accept.
  int m_last = NREQ - 1;
  bit m_out  = 1'b0;
  int m_owner = 0;
  int m_acc   = 0;

  initial begin
    forever begin
      logic [NREQ-1:0] exp_rdy;
      logic [NREQ-1:0] exp_vld;
      bit pend;
      int pk;
      @(negedge clk);
      pend = m_out && (cyc >= m_acc + LAT);
      pk = -1;
      if (!m_out && !rst) begin
        for (int k = 1; k <= NREQ; k++) begin
          int i;
          i = (m_last + k) % NREQ;
          if (pk < 0 && req_valid[i]) pk = i;
        end
      end
      exp_rdy = '0;
      if (pk >= 0) exp_rdy[pk] = 1'b1;
      exp_vld = '0;
      if (pend && !rst) exp_vld[m_owner] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, m_out);
      chk("rsp_valid", rsp_valid, exp_vld);
      if (rst) begin
        m_out  = 1'b0;
        m_last = NREQ - 1;
        sb.delete();
      end else if (pend && rsp_ready[m_owner]) begin
        m_out  = 1'b0;
        m_last = m_owner;
      end else if (pk >= 0) begin
        m_out   = 1'b1;
        m_owner = pk;
        m_acc   = cyc;
        sb.push_back('{pk, ref_mul(req_x[pk*16 +: 16], req_y[pk*16 +: 16]), cyc});
      end
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) seen = 1'b0;
      else if (rsp_valid != '0) begin
        if (sb.size() == 0) chk("unexpected rsp_valid", rsp_valid, '0);
        else begin
          exp_t e;
          logic [NREQ-1:0] oh;
          e = sb[0];
          oh = '0;
          oh[e.owner] = 1'b1;
          chk("rsp_owner", rsp_valid, oh);
          chk("rsp_z", rsp_z, e.prod);
          if (!seen) chk("latency", cyc - e.acc, LAT);
          seen = 1'b1;
          if (rsp_ready[e.owner]) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input int idx, input logic [15:0] x, input logic [15:0] y);
    bit ok;
    ok = 1'b0;
    req_x[idx*16 +: 16] = x;
    req_y[idx*16 +: 16] = y;
    req_valid[idx] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", ok, 1'b1);
    @(posedge clk);
    #1 req_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", ok, 1'b1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] c [5];
    c = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001};
    if ($urandom_range(7) == 0) return c[$urandom_range(4)];
    return 16'($urandom);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] glog[$];
    int order [5];
    int accepts;
    bit ok;
    order = '{0, 1, 2, 3, 0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = '1;

    send(0, 16'd3, 16'hFFFB);
    wait_idle();
    send(2, 16'h8000, 16'h8000);
    wait_idle();
    send(3, 16'h7FFF, 16'h8000);
    wait_idle();

    // Fairness from a fresh reset with everyone requesting.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*16 +: 16] = 16'(i + 10);
      req_y[i*16 +: 16] = 16'hFFF0 + 16'(i);
    end
    req_valid = '1;
    for (int n = 0; n < 60 && glog.size() < 5; n++) begin
      @(negedge clk);
      if (req_ready != '0) glog.push_back(req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    chk("fairness grants", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) begin
      logic [NREQ-1:0] oh;
      oh = '0;
      oh[order[i]] = 1'b1;
      chk("grant order", glog[i], oh);
    end
    wait_idle();

    // Backpressure on requester 1; other rsp_ready bits must be ignored.
    rsp_ready = 4'b1101;
    send(1, 16'h1234, 16'hC001);
    repeat (7) @(posedge clk);
    #1 rsp_ready = '1;
    wait_idle();

    // Reset while the operation is in CALC.
    send(0, 16'd7, 16'd9);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = '1;
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        ok = 1'b1;
        chk("grant after reset", req_ready, 4'b0001);
        break;
      end
    end
    chk("grant after reset seen", ok, 1'b1);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle();

    // Random traffic.
    accepts = 0;
    for (int n = 0; n < 30000 && accepts < 1000; n++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_x[i*16 +: 16] = rand_op();
        req_y[i*16 +: 16] = rand_op();
      end
      rsp_ready = NREQ'($urandom);
      @(negedge clk);
      if ((req_valid & req_ready) != '0) accepts++;
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    rsp_ready = '1;
    chk("random accepts", accepts >= 1000, 1'b1);
    wait_idle();
    chk("scoreboard empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/booth_mul_arbiter.md
BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter W, default 16, operand width; fixed at 16 to match the shared multiplier.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operand valid.
REQ-006 SHALL have port req_ready  output  NREQ  per-requester operand accepted.
REQ-007 SHALL have port req_x  input  NREQ*16  packed multiplicands; requester i occupies bits [16i+15:16i].
REQ-008 SHALL have port req_y  input  NREQ*16  packed multipliers, same packing.
REQ-009 SHALL have port rsp_valid  output  NREQ  one-hot result valid toward the owning requester.
REQ-010 SHALL have port rsp_ready  input  NREQ  per-requester result accept.
REQ-011 SHALL have port rsp_z  output  32  product, shared bus, meaningful only while any rsp_valid bit is 1.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, RESP; with BOOTH_MUL_ARB_OUTREG_EN, additionally CALC2 between CALC and RESP.
REQ-014 IDLE: if any req_valid is set, SHALL grant exactly one requester by round-robin starting after last_grant, pulse req_ready for the granted bit only in that cycle, latch x/y and the grant index, and go to CALC.
REQ-015 A transfer SHALL occur only when req_valid[i] and req_ready[i] are both 1; req_ready SHALL be 0 in every state except IDLE.
REQ-016 CALC: SHALL drive the latched operands into the multiplier, register the 32-bit product into z_reg, and go to RESP (or CALC2 when the macro is defined).
REQ-017 Products SHALL be signed two's-complement 16x16->32; -32768*-32768 = 0x40000000 with no overflow flag.
REQ-018 RESP: SHALL assert rsp_valid[grant] only; hold rsp_z and rsp_valid stable until rsp_ready[grant]=1, then return to IDLE and update last_grant.
REQ-019 rsp_ready bits of non-granted requesters SHALL be ignored.
REQ-020 Accept-to-rsp_valid latency SHALL be 2 cycles (3 with the macro); peak throughput SHALL be one operation per 3 cycles (4 with the macro).
REQ-021 A new request SHALL NOT be granted in the cycle a response completes; arbitration resumes in IDLE on the next cycle.
REQ-022 Round-robin SHALL wrap from NREQ-1 to 0; with all requesters continuously valid, each SHALL be granted once per NREQ operations.
REQ-023 A requester dropping req_valid before grant SHALL simply lose arbitration; no state is kept for it.

Reset
REQ-024 On rst=1 at a clock edge: state=IDLE, req_ready=0, rsp_valid=0, rsp_z=0, busy=0, last_grant=NREQ-1 (so requester 0 wins first).
REQ-025 Reset mid-operation SHALL discard the in-flight operation with no response produced; rst SHALL override all other inputs.

Configuration
REQ-026 Macro BOOTH_MUL_ARB_OUTREG_EN defined: SHALL add a pipeline register on the multiplier output (state CALC2), for timing.
REQ-027 Macro absent: SHALL omit CALC2 and that register; results SHALL be bit-identical in both builds, with only latency differing.

Structure
REQ-028 Shared package booth_mul_pkg SHALL hold the state encoding (IDLE=0, CALC=1, CALC2=2, RESP=3), the operand width 16, and the product width 32.
REQ-029 SHALL instantiate exactly one sub-module, the existing combinational BoothMultiplier (z, x, y); the round-robin pick SHALL be implemented inline.

Verification
REQ-030 Single request: req0 x=3, y=-5 -> req_ready[0] pulses one cycle; 2 cycles later rsp_valid=0001, rsp_z=0xFFFFFFF1.
REQ-031 Corner: x=0x8000, y=0x8000 -> rsp_z=0x40000000; x=0x7FFF, y=0x8000 -> 0xC0008000.
REQ-032 Fairness: all four req_valid held high from reset -> grant order 0,1,2,3,0; each response reaches only its requester.
REQ-033 Backpressure: rsp_ready[1]=0 for 5 cycles during RESP -> rsp_z/rsp_valid stable, req_ready stays 0000, busy=1.
REQ-034 Reset in CALC with x=7, y=9 -> no rsp_valid ever asserted; next request is granted to requester 0 and is correct.
REQ-035 Both macro builds, 1000 random operand pairs -> rsp_z equals signed x*y; latency is 2 cycles without the macro and 3 with it.
